// File: rtl/iob_fifo_sync_ram_ctrl.sv
// iob_fifo_sync_ram_ctrl
//   Synchronous FIFO controller for an external 2-port RAM with a registered
//   read port. This block holds the pointers, occupancy, flags and error
//   pulses. The RAM holds the data.
//
// Ports
//   clk, arst, rst         clock, async active-high reset, sync active-high clear
//   w_en, w_data, w_full   push side
//   r_en, r_data, r_valid  pop side (r_data valid the cycle after an accepted pop)
//   r_empty, level         occupancy status, level in 0..2**ADDR_W
//   almost_full/empty      threshold flags
//   w_overflow/r_underflow one-cycle pulses for rejected push/pop
//   ext_mem_*              RAM write/read port

module iob_fifo_sync_ram_ctrl #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 13,
    parameter int ALM_FULL_LVL  = 2**ADDR_W - 1,
    parameter int ALM_EMPTY_LVL = 1
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              r_empty,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              w_overflow,
    output logic              r_underflow,
    output logic              ext_mem_w_en,
    output logic [ADDR_W-1:0] ext_mem_w_addr,
    output logic [DATA_W-1:0] ext_mem_w_data,
    output logic              ext_mem_r_en,
    output logic [ADDR_W-1:0] ext_mem_r_addr,
    input  logic [DATA_W-1:0] ext_mem_r_data
);

    localparam logic [ADDR_W:0] LEVEL_FULL     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEVEL_ALM_FULL  = ALM_FULL_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] LEVEL_ALM_EMPTY = ALM_EMPTY_LVL[ADDR_W:0];

    // One extra pointer bit distinguishes full from empty when addresses match.
    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic            w_acc;
    logic            r_acc;

    assign level        = wptr - rptr;
    assign w_full       = (level == LEVEL_FULL);
    assign r_empty      = (level == '0);
    assign almost_full  = (level >= LEVEL_ALM_FULL);
    assign almost_empty = (level <= LEVEL_ALM_EMPTY);

    // Flags are from the current cycle only, so a same-cycle pop never makes
    // room for a push and a same-cycle push never feeds a pop. The sync clear
    // also blocks RAM accesses in its cycle.
    assign w_acc = w_en & ~w_full & ~rst;
    assign r_acc = r_en & ~r_empty & ~rst;

    assign ext_mem_w_en   = w_acc;
    assign ext_mem_w_addr = wptr[ADDR_W-1:0];
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = r_acc;
    assign ext_mem_r_addr = rptr[ADDR_W-1:0];

    // The RAM registers its read data, so this lines up with r_valid.
    assign r_data = ext_mem_r_data;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wptr        <= '0;
            rptr        <= '0;
            r_valid     <= 1'b0;
            w_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            r_valid     <= 1'b0;
            w_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            wptr        <= wptr + (ADDR_W+1)'(w_acc);
            rptr        <= rptr + (ADDR_W+1)'(r_acc);
            r_valid     <= r_acc;
            w_overflow  <= w_en & w_full;
            r_underflow <= r_en & r_empty;
        end
    end

endmodule
